// File: rtl/up_down_counter_pkg.sv
// Shared definitions for the loadable up/down counter: default width and
// the direction encoding used by the RTL and its bench.
package up_down_counter_pkg;

  localparam int DEFAULT_COUNT_WIDTH = 6;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } count_dir_e;

endpackage : up_down_counter_pkg

// File: rtl/up_down_counter_if.sv
// Control/data bundle of the up/down counter; the block that owns the
// counter sits on the slave side, whoever steers it on the master side.
interface up_down_counter_if
  import up_down_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_COUNT_WIDTH
);

  logic             LOAD;
  logic [WIDTH-1:0] DATA;
  logic             COUNT_UP;
  logic [WIDTH-1:0] COUNT;

  modport master (
    output LOAD,
    output DATA,
    output COUNT_UP,
    input  COUNT
  );

  modport slave (
    input  LOAD,
    input  DATA,
    input  COUNT_UP,
    output COUNT
  );

endinterface : up_down_counter_if

// File: rtl/up_down_counter.sv
// Free-running modulo-2^WIDTH up/down counter with synchronous reset and
// parallel load; COUNT comes straight from the state register.
module up_down_counter
  import up_down_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_COUNT_WIDTH
) (
  input  logic               CLK,
  input  logic               RESET,
  up_down_counter_if.slave   bus
);

  logic [WIDTH-1:0] count_q;
  count_dir_e       dir;

  assign dir = count_dir_e'(bus.COUNT_UP);

  // Priority is reset, then load, then step; there is no hold state, so the
  // counter moves on every edge that is neither a reset nor a load.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of count_q regardless of process ordering.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_q <= '0;
    end else if (bus.LOAD) begin
      count_q <= bus.DATA;
    end else if (dir == DIR_UP) begin
      count_q <= count_q + WIDTH'(1);
    end else begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign bus.COUNT = count_q;

`ifndef SYNTHESIS
  localparam logic [WIDTH-1:0] COUNT_MAX = '1;

  // Power-up contents are undefined, so properties wait for a first reset.
  logic seen_reset;
  always_ff @(posedge CLK) begin
    seen_reset <= (seen_reset === 1'b1) || RESET;
  end

  a_reset_value: assert property (@(posedge CLK)
    RESET |=> (count_q == '0));

  a_load_priority: assert property (@(posedge CLK)
    (!RESET && bus.LOAD) |=> (count_q == $past(bus.DATA)));

  a_wrap_up: assert property (@(posedge CLK)
    (seen_reset && !RESET && !bus.LOAD && bus.COUNT_UP && count_q == COUNT_MAX)
      |=> (count_q == '0));

  a_wrap_down: assert property (@(posedge CLK)
    (seen_reset && !RESET && !bus.LOAD && !bus.COUNT_UP && count_q == '0)
      |=> (count_q == COUNT_MAX));
`endif

endmodule : up_down_counter

// File: tb/tb_up_down_counter.sv
// Directed bench for up_down_counter: reset, load, up/down stepping, both
// wrap directions, input priority and reset in mid-count.
module tb_up_down_counter;
  import up_down_counter_pkg::*;

  localparam int WIDTH = DEFAULT_COUNT_WIDTH;

  logic CLK;
  logic RESET;

  up_down_counter_if #(.WIDTH(WIDTH)) bus ();

  up_down_counter #(.WIDTH(WIDTH)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [WIDTH-1:0] expected);
    n_checks++;
    assert (bus.COUNT === expected)
    else begin
      n_fail++;
      $error("FAIL %s: COUNT=%0d expected %0d", tag, bus.COUNT, expected);
    end
  endtask

  initial begin
    RESET        = 1'b0;
    bus.LOAD     = 1'b0;
    bus.DATA     = '0;
    bus.COUNT_UP = DIR_DOWN;
    #2;

    // Reset, then a down step from zero wraps to the top.
    RESET = 1'b1;
    step(); check("reset", 6'd0);
    RESET = 1'b0;
    step(); check("down_wrap", 6'd63);

    // Load then count down.
    bus.LOAD = 1'b1; bus.DATA = 6'b101010;
    step(); check("load_42", 6'd42);
    bus.LOAD = 1'b0;
    step(); check("down_41", 6'd41);
    step(); check("down_40", 6'd40);

    // Up two, down two from a loaded value.
    bus.LOAD = 1'b1; bus.DATA = 6'd42;
    step(); check("reload_42", 6'd42);
    bus.LOAD = 1'b0; bus.COUNT_UP = DIR_UP;
    step(); check("up_43", 6'd43);
    step(); check("up_44", 6'd44);
    bus.COUNT_UP = DIR_DOWN;
    step(); check("down_43", 6'd43);
    step(); check("down_42", 6'd42);

    // Up-wrap through the top value; COUNT_UP high during the load is ignored.
    bus.LOAD = 1'b1; bus.DATA = 6'd62; bus.COUNT_UP = DIR_UP;
    step(); check("load_62", 6'd62);
    bus.LOAD = 1'b0;
    step(); check("up_63", 6'd63);
    step(); check("up_wrap_0", 6'd0);
    step(); check("up_1", 6'd1);

    // Priority: reset beats load, load beats counting.
    RESET = 1'b1; bus.LOAD = 1'b1; bus.DATA = 6'd20;
    step(); check("reset_over_load", 6'd0);
    RESET = 1'b0;
    step(); check("load_over_up", 6'd20);
    bus.DATA = 6'd7;
    step(); check("load_held_tracks", 6'd7);
    bus.DATA = 6'd55; bus.COUNT_UP = DIR_DOWN;
    step(); check("load_held_tracks2", 6'd55);

    // Reset in mid-count, then resume upward from zero.
    bus.DATA = 6'd10;
    step(); check("load_10", 6'd10);
    bus.LOAD = 1'b0; bus.COUNT_UP = DIR_UP;
    step(); check("up_11", 6'd11);
    step(); check("up_12", 6'd12);
    RESET = 1'b1;
    step(); check("reset_midcount", 6'd0);
    RESET = 1'b0;
    step(); check("resume_1", 6'd1);
    step(); check("resume_2", 6'd2);
    step(); check("resume_3", 6'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_up_down_counter
